// File: rtl/types_pkg.sv
// Shared types for the output strategy path.
// output_signals_t is the bus that a strategy drives. The recorder monitors it.
package types_pkg;

    typedef logic [7:0] output_signals_t;

endpackage

// File: rtl/output_event_recorder.sv
// output_event_recorder
//   Watches the strategy output bus. Every cycle in which it differs from the
//   previous cycle's value (with enable high), {sig, timestamp} is queued in a
//   small first-word-fall-through FIFO. Software drains that FIFO through a
//   valid/ready port. The recorder is a passive tap and never drives sig.
//
// Ports
//   clock     : single clock domain
//   reset     : asynchronous, active-low reset
//   sig       : monitored strategy output bus
//   enable    : record changes while high
//   clear     : synchronous flush (FIFO, overflow flag, timestamp)
//   rd_ready  : reader accepts the head entry
//   rd_valid  : FIFO not empty
//   rd_data   : sig value of the head entry
//   rd_time   : timestamp of the head entry
//   level     : number of stored entries
//   overflow  : sticky; an event was dropped because the FIFO was full
module output_event_recorder
    import types_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TS_W  = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  output_signals_t            sig,
    input  logic                       enable,
    input  logic                       clear,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output output_signals_t            rd_data,
    output logic [TS_W-1:0]            rd_time,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] FULL_X  = {1'b1, {AW{1'b0}}};

    logic [TS_W-1:0]   ts_q;
    output_signals_t   prev_q;
    logic [AW:0]       wptr_q, rptr_q;
    logic              overflow_q;

    output_signals_t   mem_data [DEPTH];
    logic [TS_W-1:0]   mem_time [DEPTH];

    logic empty, full, pop, evt, push, drop;

    // The extra MSB on each pointer tells full apart from empty.
    assign empty = (wptr_q == rptr_q);
    assign full  = ((wptr_q ^ rptr_q) == FULL_X);

    assign pop  = !empty && rd_ready;
    assign evt  = enable && (sig != prev_q);
    // When the FIFO is full, a pop in the same cycle makes room for the push.
    assign push = evt && (!full || pop);
    assign drop = evt && full && !pop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts_q       <= '0;
            prev_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            // prev tracks sig regardless of enable/clear so no stale event appears later.
            prev_q <= sig;
            if (clear) begin
                ts_q       <= '0;
                wptr_q     <= '0;
                rptr_q     <= '0;
                overflow_q <= 1'b0;
            end else begin
                ts_q <= ts_q + {{(TS_W-1){1'b0}}, 1'b1};
                if (push) wptr_q <= wptr_q + PTR_ONE;
                if (pop)  rptr_q <= rptr_q + PTR_ONE;
                if (drop) overflow_q <= 1'b1;
            end
        end
    end

    // Storage array has no reset. Entries become visible only through the pointers.
    always_ff @(posedge clock) begin
        if (!clear && push) begin
            mem_data[wptr_q[AW-1:0]] <= sig;
            mem_time[wptr_q[AW-1:0]] <= ts_q;
        end
    end

    assign rd_valid = !empty;
    assign level    = wptr_q - rptr_q;
    assign overflow = overflow_q;
    // Zero the head when empty so reset shows clean values over uninitialised storage.
    assign rd_data  = empty ? '0 : mem_data[rptr_q[AW-1:0]];
    assign rd_time  = empty ? '0 : mem_time[rptr_q[AW-1:0]];

endmodule

// File: tb/tb_output_event_recorder.sv
module tb_output_event_recorder;
    import types_pkg::*;

    localparam int DEPTH = 16;
    localparam int TS_W  = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    output_signals_t sig = '0;
    logic            enable = 1'b0, clear = 1'b0, rd_ready = 1'b0;
    logic            rd_valid, overflow;
    output_signals_t rd_data;
    logic [TS_W-1:0] rd_time;
    logic [$clog2(DEPTH):0] level;

    output_event_recorder #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clock(clock), .reset(reset), .sig(sig), .enable(enable), .clear(clear),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_time(rd_time), .level(level), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0]      d;
        logic [TS_W-1:0] t;
    } ent_t;

    typedef struct {
        logic [7:0] s;
        logic       en, clr, rdy;
        int         lvl;
    } vec_t;

    ent_t sb[$];
    vec_t tbl[$];
    int   m_ts;
    logic [7:0] m_prev;
    bit   m_ovf;
    int   nvec = 0, nerr = 0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_ts = 0; m_prev = '0; m_ovf = 0;
    endtask

    // Drive one cycle's inputs, compare the head on pops, advance the model, then check after the edge.
    task automatic step(input logic [7:0] s, input logic en, input logic clr, input logic rdy);
        bit   pop, ev;
        ent_t h;
        sig = s; enable = en; clear = clr; rd_ready = rdy;
        #1;
        pop = (sb.size() > 0) && rdy;
        if (pop) begin
            chk("head_data", int'(rd_data), int'(sb[0].d));
            chk("head_time", int'(rd_time), int'(sb[0].t));
        end
        if (clr) begin
            sb.delete(); m_ovf = 0; m_ts = 0;
        end else begin
            ev = en && (s != m_prev);
            if (pop) h = sb.pop_front();
            if (ev) begin
                if (sb.size() < DEPTH) sb.push_back({s, m_ts[TS_W-1:0]});
                else m_ovf = 1;
            end
            m_ts = (m_ts + 1) % (1 << TS_W);
        end
        m_prev = s;
        @(posedge clock); #1;
        chk("level", int'(level), sb.size());
        chk("rd_valid", int'(rd_valid), int'(sb.size() > 0));
        chk("overflow", int'(overflow), int'(m_ovf));
    endtask

    task automatic do_reset();
        reset = 1'b0; sig = '0; enable = 0; clear = 0; rd_ready = 0;
        @(posedge clock); #1;
        chk("rst_level", int'(level), 0);
        chk("rst_valid", int'(rd_valid), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_data", int'(rd_data), 0);
        chk("rst_time", int'(rd_time), 0);
        reset = 1'b1;
        model_reset();
    endtask

    function automatic void add(input logic [7:0] s, input logic en, input logic clr,
                                input logic rdy, input int lvl);
        vec_t v;
        v.s = s; v.en = en; v.clr = clr; v.rdy = rdy; v.lvl = lvl;
        tbl.push_back(v);
    endfunction

    task automatic run_tbl();
        foreach (tbl[i]) begin
            step(tbl[i].s, tbl[i].en, tbl[i].clr, tbl[i].rdy);
            chk("tbl_level", int'(level), tbl[i].lvl);
        end
        tbl.delete();
    endtask

    initial begin
        // Basic capture: changes at ts=10 and ts=14, then drain.
        do_reset();
        for (int i = 0; i < 10; i++) add(8'h0, 1, 0, 0, 0);
        add(8'h5, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) add(8'h5, 1, 0, 0, 1);
        add(8'h3, 1, 0, 0, 2);
        add(8'h3, 1, 0, 1, 1);   // pops (5,10)
        add(8'h3, 1, 0, 1, 0);   // pops (3,14)
        add(8'h3, 1, 0, 1, 0);   // ready while empty is ignored
        run_tbl();

        // Enable gating.
        do_reset();
        for (int i = 0; i < 5; i++) add(8'h0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(8'h7, 0, 0, 0, 0);
        add(8'h7, 1, 0, 0, 0);   // ts=8: enabled, sig unchanged, no entry
        add(8'h1, 1, 0, 0, 1);   // ts=9: entry (1,9)
        add(8'h1, 1, 0, 1, 0);
        run_tbl();

        // Overflow: 20 consecutive changes into a 16-entry FIFO.
        do_reset();
        for (int i = 0; i < 20; i++) step(8'(i + 1), 1, 0, 0);
        chk("ovf_level", int'(level), 16);
        chk("ovf_flag", int'(overflow), 1);
        for (int i = 0; i < 16; i++) step(8'd20, 1, 0, 1);
        chk("ovf_drained", int'(level), 0);
        chk("ovf_sticky", int'(overflow), 1);

        // Full FIFO with simultaneous push and pop.
        step(8'd20, 1, 1, 0);
        chk("clr_ovf", int'(overflow), 0);
        for (int i = 0; i < 16; i++) step(8'(30 + i), 1, 0, 0);
        chk("full_level", int'(level), 16);
        for (int i = 0; i < 3; i++) step(8'(50 + i), 1, 0, 1);
        chk("pp_level", int'(level), 16);
        chk("pp_ovf", int'(overflow), 0);
        for (int i = 0; i < 16; i++) step(8'd52, 1, 0, 1);
        chk("pp_drained", int'(level), 0);

        // Timestamp wrap and clear priority.
        do_reset();
        for (int i = 0; i < 15; i++) step(8'h0, 1, 0, 0);
        step(8'h1, 1, 0, 0);     // ts=15
        step(8'h1, 1, 0, 0);     // ts=0
        step(8'h2, 1, 0, 0);     // ts=1
        chk("wrap_level", int'(level), 2);
        step(8'h2, 1, 0, 1);     // pops (1,15)
        step(8'h2, 1, 0, 1);     // pops (2,1)
        step(8'h9, 1, 0, 0);     // queue an entry so clear has something to flush
        step(8'h3, 1, 1, 0);     // clear and change in the same cycle
        chk("clr_level", int'(level), 0);
        chk("clr_ovf2", int'(overflow), 0);
        step(8'h3, 1, 0, 0);     // ts=0, no change
        step(8'h4, 1, 0, 0);     // ts=1
        chk("clr_ts_data", int'(rd_data), 4);
        chk("clr_ts_time", int'(rd_time), 1);
        step(8'h4, 1, 0, 1);

        // Asynchronous reset mid-stream.
        do_reset();
        for (int i = 0; i < 5; i++) step(8'(i + 1), 1, 0, 0);
        chk("ar_pre_level", int'(level), 5);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid", int'(rd_valid), 0);
        chk("ar_level", int'(level), 0);
        chk("ar_data", int'(rd_data), 0);
        chk("ar_time", int'(rd_time), 0);
        @(posedge clock); #1;
        reset = 1'b1;
        model_reset();
        step(8'h9, 1, 0, 0);
        chk("ar_first_time", int'(rd_time), 0);
        chk("ar_first_data", int'(rd_data), 9);
        step(8'h9, 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/output_event_recorder.md
# output_event_recorder

Receive-side counterpart to the output strategies: it samples the `output_signals_t` bus a strategy drives, detects every change, and queues each new value with a cycle timestamp in a small FIFO. Software reads the queue through a valid/ready port. The recorder sits between the strategy output and the readout/register interface. It shows exactly what the strategy produced and when, with no effect on the signal path.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `TS_W`, 32: timestamp counter width.

Ports:
- `clock`  in  1: single clock domain.
- `reset`  in  1: asynchronous, active-low reset.
- `sig`  in  `$bits(output_signals_t)`: strategy output bus being monitored (`output_signals_t` from `types_pkg`).
- `enable`  in  1: when high, changes are recorded.
- `clear`  in  1: synchronous flush.
- `rd_ready`  in  1: reader accepts the head entry.
- `rd_valid`  out  1: FIFO not empty.
- `rd_data`  out  `output_signals_t`: sig value of the head entry.
- `rd_time`  out  TS_W: timestamp of the head entry.
- `level`  out  `$clog2(DEPTH)+1`: number of stored entries.
- `overflow`  out  1: sticky flag; set when an event was dropped.

## Operation
- **Timestamp counter `ts`:** free-running; +1 every clock; wraps from 2^TS_W−1 to 0 with no flag.
- **Previous-value register `prev`:** loads `sig` every clock, whether or not `enable` is high, so re-enabling never produces a stale event.
- **Event:** `enable && (sig != prev)` at a clock edge.
  - The event pushes `{sig, ts}`, using the pre-increment `ts` value of that edge.
  - One entry per differing cycle, even if `sig` changes on consecutive cycles.
- **FIFO:** circular buffer, write and read pointers `$clog2(DEPTH)+1` bits wide (extra wrap bit).
  - full = pointers equal except the MSB; empty = pointers equal.
  - Head is shown first-word-fall-through: `rd_data`/`rd_time` are valid whenever `rd_valid` is high.
  - Head values are don't-care when `rd_valid` is low.
- **Pop:** `rd_valid && rd_ready` at a clock edge. `rd_ready` while empty is ignored.
- **Push while full, no pop:** the event is dropped and `overflow` is set. Stored contents are unchanged.
- **Push and pop together while full:** both are performed; `level` stays at DEPTH and `overflow` is not set.
- **Push and pop together while non-full, non-empty:** `level` is unchanged.
- **`clear`:** has priority over push and pop in the same cycle.
  - Empties the FIFO, clears `overflow`, sets `ts` to 0.
  - `prev` still loads `sig`.
  - An event in the same cycle is discarded.
- **`overflow`:** cleared only by `clear` or reset.

## Timing
- Reset (asynchronous, `reset` low) sets `ts`=0, `prev`='0, both pointers to 0, `overflow`=0.
  - During reset: `rd_valid`=0, `level`=0, `rd_data`='0, `rd_time`=0.
- First clock after reset release with `enable`=1 and `sig`≠0 records an event with `rd_time`=0.
- **Latency:** event at edge N gives `rd_valid`=1 and an updated `level` after edge N.
  - 1 cycle from the sampled change to visibility.
- **Pop:** at edge N, the next entry (or `rd_valid`=0) is visible after edge N.
- **Registered outputs:** `level`, `overflow` and `rd_valid` come directly from registers/pointer compare; no combinational path from `rd_ready`.
  - `rd_data`/`rd_time` are a memory read at the read pointer (no input-to-output comb path).
- Reset asserted mid-operation discards all entries immediately; no partial state is retained.

## Test plan
- **Basic capture:** reset, `enable`=1, sig 0→0x5 at ts=10, →0x3 at ts=14; `rd_ready`=0 → `level`=2.
  - Then pulse `rd_ready` → read (0x5,10), then (0x3,14), then `rd_valid`=0.
- **Enable gating:** `enable`=0, sig 0→0x7 at ts=5; `enable`=1 at ts=8 with sig still 0x7 → no entry, `level`=0.
  - sig→0x1 at ts=9 → one entry (0x1,9).
- **Overflow:** DEPTH=16, toggle sig every cycle for 20 cycles, `rd_ready`=0 → `level`=16, `overflow`=1.
  - Entries are the first 16 values with consecutive timestamps; the 4 later events are lost.
- **Full with simultaneous push/pop:** FIFO full, `rd_ready`=1, sig changes → `level` stays 16, `overflow` stays 0.
  - Head advances; the newest entry is at the tail.
- **Clear priority and timestamp wrap:** TS_W=4, change at ts=15 then at ts=1 → rd_time 15 then 1.
  - Assert `clear` in the same cycle as a change → `level`=0, `overflow`=0.
  - The next change lands at ts=1 relative to the clear.
- **Async reset mid-stream:** 5 entries queued, pull `reset` low between edges → `rd_valid`=0 and `level`=0 immediately.
  - After release, `ts` restarts at 0.
